moore_updown_fsm: RTL



---
 rtl/moore_fsm_pkg.sv | 31 +++
 rtl/fsm_dwell_timer.sv | 34 +++
 rtl/moore_updown_fsm.sv | 109 ++++++++++
 3 files changed

// File: rtl/moore_fsm_pkg.sv
// Shared constants and helpers for the moore_updown_fsm sequencer.
// Optional dwell feature is selected with the FSM_DWELL_EN macro.
package moore_fsm_pkg;

    // Direction encoding on i_dir
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // End-state behaviour selected by the WRAP parameter
    localparam int MODE_SAT  = 0;
    localparam int MODE_WRAP = 1;

    // Ceiling log2, evaluated at elaboration time for counter widths
    function automatic int f_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Counter width that can hold 0..depth-1, never narrower than one bit
    function automatic int f_cnt_width(input int depth);
        return (f_clog2(depth) < 1) ? 1 : f_clog2(depth);
    endfunction

endpackage

// File: rtl/fsm_dwell_timer.sv
// Dwell timer: counts enabled cycles and ticks on the last cycle of each
// dwell period. Only instantiated when FSM_DWELL_EN is defined.
module fsm_dwell_timer
    import moore_fsm_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic o_tick
);

    localparam int CNT_W = f_cnt_width(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Tick is the enabled edge on which the dwell period completes
    assign o_tick = en && (r_cnt == LP_LAST);

    // Dwell count: cleared by reset or load, wraps to 0 on a tick, holds when idle
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/moore_updown_fsm.sv
// Parametrised Moore up/down state sequencer with wrap or saturate ends,
// synchronous load with clamping, and registered min/max/wrap status.
// Define FSM_DWELL_EN to spend DWELL_CYCLES enabled cycles in each state.
module moore_updown_fsm
    import moore_fsm_pkg::*;
#(
    parameter int NUM_STATES   = 6,
    parameter int STATE_W      = 3,
    parameter int WRAP         = 1,
    parameter int DWELL_CYCLES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_dir,
    input  logic               i_load,
    input  logic [STATE_W-1:0] i_load_val,
    output logic [STATE_W-1:0] o_state,
    output logic               o_max,
    output logic               o_min,
    output logic               o_wrap
);

    localparam logic [STATE_W-1:0] LP_TOP = STATE_W'(NUM_STATES - 1);

    // Reject configurations that cannot encode the requested state space
    if (NUM_STATES < 2) begin : g_bad_num_states
        $error("moore_updown_fsm: NUM_STATES must be at least 2");
    end
    if ((2 ** STATE_W) < NUM_STATES) begin : g_bad_state_w
        $error("moore_updown_fsm: STATE_W too narrow for NUM_STATES");
    end
    if (DWELL_CYCLES < 1) begin : g_bad_dwell
        $error("moore_updown_fsm: DWELL_CYCLES must be at least 1");
    end

    logic [STATE_W-1:0] r_state;
    logic               r_wrap;
    logic [STATE_W-1:0] w_next_state;
    logic               w_next_wrap;
    logic               w_step;
    logic               w_illegal;

`ifdef FSM_DWELL_EN
    fsm_dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell (
        .clk    (i_clk),
        .rst    (i_rst),
        .en     (i_en),
        .clr    (i_load),
        .o_tick (w_step)
    );
`else
    assign w_step = i_en;
`endif

    assign w_illegal = (r_state > LP_TOP);

    // State register: synchronous reset, otherwise take the computed next state
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (i_rst) begin
            r_state <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_wrap  <= w_next_wrap;
        end
    end

    // Next-state logic: illegal recovery > load (clamped) > step > hold
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        w_next_state = r_state;
        w_next_wrap  = 1'b0;
        if (w_illegal) begin
            w_next_state = '0;
        end else if (i_load) begin
            w_next_state = (i_load_val > LP_TOP) ? LP_TOP : i_load_val;
        end else if (w_step) begin
            if (i_dir == DIR_UP) begin
                if (r_state != LP_TOP) begin
                    w_next_state = r_state + STATE_W'(1);
                end else if (WRAP == MODE_WRAP) begin
                    w_next_state = '0;
                    w_next_wrap  = 1'b1;
                end
            end else begin
                if (r_state != '0) begin
                    w_next_state = r_state - STATE_W'(1);
                end else if (WRAP == MODE_WRAP) begin
                    w_next_state = LP_TOP;
                    w_next_wrap  = 1'b1;
                end
            end
        end
    end

    // Moore outputs: decoded from registered state only
    always_comb begin
        o_state = r_state;
        o_wrap  = r_wrap;
        o_max   = (r_state == LP_TOP);
        o_min   = (r_state == '0);
    end

endmodule
